// File: rtl/img_mem_arbiter.sv
// Arbiter for the single-port image memory: VGA scan-out has priority over the zoom/host engine.
// Define ARB_STARVE_GUARD_EN to force-grant the engine after MAX_WAIT consecutive denied cycles.
module img_mem_arbiter #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 18,
    parameter int RD_LATENCY = 2,
    parameter int MAX_WAIT   = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              vga_rvalid,
    input  logic              alg_req,
    input  logic              alg_we,
    input  logic [ADDR_W-1:0] alg_addr,
    input  logic [DATA_W-1:0] alg_wdata,
    output logic              alg_gnt,
    output logic [DATA_W-1:0] alg_rdata,
    output logic              alg_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q,
    output logic [2:0]        starve_cnt
);

    typedef enum logic [1:0] {IDLE, GNT_VGA, GNT_ALG_RD, GNT_ALG_WR} state_t;

    state_t                state, state_nxt;
    logic                  guard_fire;
    logic [2:0]            starve_nxt;
    logic                  rd_issue;
    logic [RD_LATENCY-1:0] tag_vld_p;
    logic [RD_LATENCY-1:0] tag_alg_p;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [2:0] WAIT_MAX = 3'(MAX_WAIT);

    function automatic logic [2:0] sat_inc(input logic [2:0] v);
        if (v >= WAIT_MAX)
            return WAIT_MAX;
        return v + 3'd1;
    endfunction

    logic alg_issue;

    assign guard_fire = (starve_cnt == WAIT_MAX);
    assign alg_issue  = (state_nxt == GNT_ALG_RD) || (state_nxt == GNT_ALG_WR);
    assign starve_nxt = (alg_req && !alg_issue) ? sat_inc(starve_cnt) : 3'd0;
`else
    assign guard_fire = 1'b0;
    assign starve_nxt = 3'd0;
`endif

    // Slot decision from the requests sampled this cycle
    always_comb begin
        state_nxt = IDLE;
        if (vga_req && !(alg_req && guard_fire))
            state_nxt = GNT_VGA;
        else if (alg_req)
            state_nxt = alg_we ? GNT_ALG_WR : GNT_ALG_RD;
    end

    assign rd_issue = (state_nxt == GNT_VGA) || (state_nxt == GNT_ALG_RD);

    assign vga_gnt  = (state == GNT_VGA);
    assign alg_gnt  = (state == GNT_ALG_RD) || (state == GNT_ALG_WR);
    assign mem_wren = (state == GNT_ALG_WR);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= 3'd0;
            mem_addr   <= '0;
            mem_data   <= '0;
            tag_vld_p  <= '0;
            tag_alg_p  <= '0;
            vga_rvalid <= 1'b0;
            alg_rvalid <= 1'b0;
            vga_rdata  <= '0;
            alg_rdata  <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            case (state_nxt)
                GNT_VGA:    mem_addr <= vga_addr;
                GNT_ALG_RD: mem_addr <= alg_addr;
                GNT_ALG_WR: begin
                    mem_addr <= alg_addr;
                    mem_data <= alg_wdata;
                end
                default: ;
            endcase

            // Read tag pipeline: stage 0 enters with the issued slot
            tag_vld_p[0] <= rd_issue;
            tag_alg_p[0] <= (state_nxt == GNT_ALG_RD);
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_vld_p[i] <= tag_vld_p[i-1];
                tag_alg_p[i] <= tag_alg_p[i-1];
            end

            // Tail: memory data is captured for the owning requester
            vga_rvalid <= tag_vld_p[RD_LATENCY-1] && !tag_alg_p[RD_LATENCY-1];
            alg_rvalid <= tag_vld_p[RD_LATENCY-1] &&  tag_alg_p[RD_LATENCY-1];
            if (tag_vld_p[RD_LATENCY-1] && !tag_alg_p[RD_LATENCY-1])
                vga_rdata <= mem_q;
            if (tag_vld_p[RD_LATENCY-1] && tag_alg_p[RD_LATENCY-1])
                alg_rdata <= mem_q;
        end
    end

endmodule

// File: tb/tb_img_mem_arbiter.sv
// Bench for img_mem_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_img_mem_arbiter;

    localparam int RD_LAT   = 2;
    localparam int MAX_WAIT = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        vga_req;
    logic [17:0] vga_addr;
    logic        vga_gnt;
    logic [7:0]  vga_rdata;
    logic        vga_rvalid;
    logic        alg_req;
    logic        alg_we;
    logic [17:0] alg_addr;
    logic [7:0]  alg_wdata;
    logic        alg_gnt;
    logic [7:0]  alg_rdata;
    logic        alg_rvalid;
    logic [17:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_wren;
    logic [7:0]  mem_q;
    logic [2:0]  starve_cnt;

    img_mem_arbiter dut (
        .clock(clock), .reset(reset),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
        .vga_rdata(vga_rdata), .vga_rvalid(vga_rvalid),
        .alg_req(alg_req), .alg_we(alg_we), .alg_addr(alg_addr), .alg_wdata(alg_wdata),
        .alg_gnt(alg_gnt), .alg_rdata(alg_rdata), .alg_rvalid(alg_rvalid),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
        .mem_q(mem_q), .starve_cnt(starve_cnt)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Power-up image contents; 0x00010 holds 0xA5
    function automatic logic [7:0] init_val(input logic [17:0] a);
        if (a == 18'h00010)
            return 8'hA5;
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Memory block: one registered read stage, write on wren
    logic [7:0] tb_mem [logic [17:0]];
    function automatic logic [7:0] mem_rd(input logic [17:0] a);
        return tb_mem.exists(a) ? tb_mem[a] : init_val(a);
    endfunction
    always @(posedge clock) begin
        mem_q <= mem_rd(mem_addr);
        if (mem_wren)
            tb_mem[mem_addr] = mem_data;
    end

    // Reference model
    typedef struct { int due; bit alg; logic [7:0] d; } rd_t;
    rd_t        rdq[$];
    logic [7:0] ref_mem [logic [17:0]];
    int         m_wait;
    bit         m_vgnt, m_agnt, m_wren, m_vrv, m_arv;
    logic [17:0] m_addr;
    logic [7:0]  m_data, m_vrdata, m_ardata;

    function automatic logic [7:0] ref_rd(input logic [17:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    task automatic tick();
        bit rv, vr, ar, we, alg_win;
        logic [17:0] va, aa;
        logic [7:0]  wd;
        rd_t r;
        rv = reset; vr = vga_req; ar = alg_req; we = alg_we;
        va = vga_addr; aa = alg_addr; wd = alg_wdata;
        @(posedge clock);
        #1;
        cyc++;
        m_vrv = 1'b0;
        m_arv = 1'b0;
        if (rv) begin
            m_vgnt = 0; m_agnt = 0; m_wren = 0; m_wait = 0;
            m_addr = '0; m_data = '0; m_vrdata = '0; m_ardata = '0;
            rdq.delete();
        end else begin
            alg_win = ar && (!vr || (GUARD && m_wait == MAX_WAIT));
            m_vgnt  = vr && !alg_win;
            m_agnt  = alg_win;
            m_wren  = alg_win && we;
            if (m_vgnt) begin
                m_addr = va;
                rdq.push_back('{due: cyc + RD_LAT, alg: 1'b0, d: ref_rd(va)});
            end else if (alg_win) begin
                m_addr = aa;
                if (we) begin
                    m_data = wd;
                    ref_mem[aa] = wd;
                end else begin
                    rdq.push_back('{due: cyc + RD_LAT, alg: 1'b1, d: ref_rd(aa)});
                end
            end
            if (GUARD && ar && !alg_win)
                m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
            else
                m_wait = 0;
            if (rdq.size() > 0 && rdq[0].due == cyc) begin
                r = rdq.pop_front();
                if (r.alg) begin m_arv = 1'b1; m_ardata = r.d; end
                else       begin m_vrv = 1'b1; m_vrdata = r.d; end
            end
        end
    endtask

    task automatic idle_inputs();
        vga_req = 0; alg_req = 0; alg_we = 0;
        vga_addr = '0; alg_addr = '0; alg_wdata = '0;
    endtask

    task automatic test_reset();
        reset = 1;
        vga_req = 1; alg_req = 1; alg_we = 1;
        vga_addr = 18'h00123; alg_addr = 18'h00456; alg_wdata = 8'h77;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if ({vga_gnt, alg_gnt, mem_wren, vga_rvalid, alg_rvalid} !== 5'b0) begin
                n_fail++;
                $display("FAIL reset_ctrl: got %b want 00000", {vga_gnt, alg_gnt, mem_wren, vga_rvalid, alg_rvalid});
            end
            n_checks++;
            if ({mem_addr, mem_data, vga_rdata, alg_rdata, starve_cnt} !== 45'b0) begin
                n_fail++;
                $display("FAIL reset_data: addr %h data %h vrd %h ard %h cnt %0d want all 0",
                         mem_addr, mem_data, vga_rdata, alg_rdata, starve_cnt);
            end
        end
        reset = 0;
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_vga_read();
        vga_req = 1; vga_addr = 18'h00010;
        tick();
        n_checks++;
        if ({vga_gnt, alg_gnt, mem_wren} !== 3'b100 || mem_addr !== 18'h00010) begin
            n_fail++;
            $display("FAIL vga_gnt: got gnt %b/%b wren %b addr %h want 1/0 0 00010", vga_gnt, alg_gnt, mem_wren, mem_addr);
        end
        vga_req = 0;
        tick();
        n_checks++;
        if (vga_gnt !== 1'b0 || vga_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL vga_early: got gnt %b rvalid %b want 0 0", vga_gnt, vga_rvalid);
        end
        tick();
        n_checks++;
        if (vga_rvalid !== 1'b1 || vga_rdata !== 8'hA5 || alg_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL vga_rdata: got rvalid %b data %h alg_rvalid %b want 1 a5 0", vga_rvalid, vga_rdata, alg_rvalid);
        end
        tick();
        n_checks++;
        if (vga_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL vga_rvalid_pulse: got %b want 0", vga_rvalid);
        end
    endtask

    task automatic test_write_read_b2b();
        alg_req = 1; alg_we = 1; alg_addr = 18'h12C00; alg_wdata = 8'h3C;
        tick();
        n_checks++;
        if (alg_gnt !== 1'b1 || mem_wren !== 1'b1 || mem_addr !== 18'h12C00 || mem_data !== 8'h3C) begin
            n_fail++;
            $display("FAIL alg_write: got gnt %b wren %b addr %h data %h want 1 1 12c00 3c", alg_gnt, mem_wren, mem_addr, mem_data);
        end
        alg_we = 0; alg_wdata = 8'h00;
        tick();
        n_checks++;
        if (alg_gnt !== 1'b1 || mem_wren !== 1'b0 || mem_addr !== 18'h12C00) begin
            n_fail++;
            $display("FAIL alg_read_gnt: got gnt %b wren %b addr %h want 1 0 12c00", alg_gnt, mem_wren, mem_addr);
        end
        alg_req = 0;
        tick();
        n_checks++;
        if (alg_rvalid !== 1'b0 || mem_wren !== 1'b0) begin
            n_fail++;
            $display("FAIL alg_early: got rvalid %b wren %b want 0 0", alg_rvalid, mem_wren);
        end
        tick();
        n_checks++;
        if (alg_rvalid !== 1'b1 || alg_rdata !== 8'h3C || vga_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL alg_rdata: got rvalid %b data %h vga_rvalid %b want 1 3c 0", alg_rvalid, alg_rdata, vga_rvalid);
        end
        tick();
    endtask

    task automatic test_contention();
        bit exp_alg;
        logic [2:0] exp_cnt;
        vga_req = 1; vga_addr = 18'h00020;
        alg_req = 1; alg_we = 0; alg_addr = 18'h00030;
        for (int i = 0; i < 15; i++) begin
            tick();
`ifdef ARB_STARVE_GUARD_EN
            exp_alg = (i % 5 == 4);
            exp_cnt = exp_alg ? 3'd0 : 3'(i % 5 + 1);
`else
            exp_alg = 1'b0;
            exp_cnt = 3'd0;
`endif
            n_checks++;
            if (alg_gnt !== exp_alg || vga_gnt !== !exp_alg || starve_cnt !== exp_cnt) begin
                n_fail++;
                $display("FAIL contention[%0d]: got vga %b alg %b cnt %0d want vga %b alg %b cnt %0d",
                         i, vga_gnt, alg_gnt, starve_cnt, !exp_alg, exp_alg, exp_cnt);
            end
        end
        vga_req = 0;
        tick();
        n_checks++;
        if (alg_gnt !== 1'b1 || vga_gnt !== 1'b0 || starve_cnt !== 3'd0) begin
            n_fail++;
            $display("FAIL vga_drop: got alg %b vga %b cnt %0d want 1 0 0", alg_gnt, vga_gnt, starve_cnt);
        end
        alg_req = 0;
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_reset_midread();
        vga_req = 1; vga_addr = 18'h00040;
        tick();
        n_checks++;
        if (vga_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL midread_gnt: got %b want 1", vga_gnt);
        end
        vga_req = 0;
        tick();
        reset = 1;
        tick();
        reset = 0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (vga_rvalid !== 1'b0 || alg_rvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL midread_discard[%0d]: got rvalid %b/%b want 0/0", i, vga_rvalid, alg_rvalid);
            end
            tick();
        end
        vga_req = 1; vga_addr = 18'h00010;
        tick();
        vga_req = 0;
        tick();
        tick();
        n_checks++;
        if (vga_rvalid !== 1'b1 || vga_rdata !== 8'hA5) begin
            n_fail++;
            $display("FAIL after_reset_read: got rvalid %b data %h want 1 a5", vga_rvalid, vga_rdata);
        end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if (!vga_req || vga_gnt) begin
                vga_req  = ($urandom_range(0, 3) != 0);
                vga_addr = 18'h00100 + 18'($urandom_range(0, 15));
            end else if ($urandom_range(0, 15) == 0) begin
                vga_req = 0;
            end
            if (!alg_req || alg_gnt) begin
                alg_req   = ($urandom_range(0, 2) != 0);
                alg_we    = $urandom_range(0, 1) != 0;
                alg_addr  = 18'h00100 + 18'($urandom_range(0, 15));
                alg_wdata = 8'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
                alg_req = 0;
            end
            reset = ($urandom_range(0, 99) == 0);
            tick();
            n_checks++;
            if ({vga_gnt, alg_gnt, mem_wren, vga_rvalid, alg_rvalid} !== {m_vgnt, m_agnt, m_wren, m_vrv, m_arv}) begin
                n_fail++;
                $display("FAIL rand_ctrl@%0d: got %b want %b", cyc,
                         {vga_gnt, alg_gnt, mem_wren, vga_rvalid, alg_rvalid}, {m_vgnt, m_agnt, m_wren, m_vrv, m_arv});
            end
            n_checks++;
            if (mem_addr !== m_addr || mem_data !== m_data) begin
                n_fail++;
                $display("FAIL rand_port@%0d: got addr %h data %h want %h %h", cyc, mem_addr, mem_data, m_addr, m_data);
            end
            n_checks++;
            if (vga_rdata !== m_vrdata || alg_rdata !== m_ardata) begin
                n_fail++;
                $display("FAIL rand_rdata@%0d: got %h/%h want %h/%h", cyc, vga_rdata, alg_rdata, m_vrdata, m_ardata);
            end
            n_checks++;
            if (starve_cnt !== 3'(m_wait)) begin
                n_fail++;
                $display("FAIL rand_starve@%0d: got %0d want %0d", cyc, starve_cnt, m_wait);
            end
        end
        reset = 0;
        idle_inputs();
        for (int i = 0; i < 4; i++) tick();
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_vga_read();
        test_write_read_b2b();
        test_contention();
        test_reset_midread();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
